// File: rtl/sram_arb_pkg.sv
// Shared types and sizing for the SRAM access arbiter.
//   state_t : access sequencer phases
//   ADDR_W  : SRAM address width
//   DATA_W  : SRAM data width
//   max2    : helper for sizing the phase counter
package sram_arb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Bundle of the two requester handshakes and the SRAM pins.
//   master : client/SRAM side (drives requests, operands and sram_dout)
//   slave  : arbiter side (drives grants, completions, read data and SRAM pins)
interface sram_access_arbiter_if;
  import sram_arb_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              sram_cs;
  logic              sram_rw_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dout,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
    input  sram_cs, sram_rw_en, sram_addr, sram_din
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dout,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
    output sram_cs, sram_rw_en, sram_addr, sram_din
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req0, req1  : pending requests
//   last_served : port granted most recently
//   any_req     : at least one request pending
//   pick        : winning port (0 or 1), meaningful when any_req is high
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic any_req,
  output logic pick
);

  assign any_req = req0 | req1;

  // On a tie the port that was not served last wins; otherwise the lone
  // requester wins (req1 alone -> 1, req0 alone -> 0).
  assign pick = (req0 && req1) ? ~last_served : req1;

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one asynchronous SRAM between two synchronous requesters.
// Each access is sequenced SETUP -> ACCESS -> HOLD so that the SRAM
// address and read/write select are settled before chip select falls and
// stay put until it rises again.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : requester handshakes and SRAM pins (slave modport)
// Parameters:
//   SETUP_CYC  : cycles with operands on the pins and CS high before CS falls
//   ACCESS_CYC : cycles with CS low; read data captured on the last one
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_access_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(max2(SETUP_CYC, ACCESS_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic             winner;
  logic             last_served;
  logic             any_req;
  logic             pick;

  rr_arb2 u_rr_arb2 (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_served (last_served),
    .any_req     (any_req),
    .pick        (pick)
  );

  // The SRAM pin registers double as the operand latch: they are loaded at
  // grant time and left untouched until the access has finished, which is
  // what keeps address and rw_en frozen while CS is low. sram_rw_en itself
  // tells the ACCESS phase whether the winner asked for a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      phase_cnt      <= '0;
      winner         <= 1'b0;
      last_served    <= 1'b1;
      bus.sram_cs    <= 1'b1;
      bus.sram_rw_en <= 1'b1;
      bus.sram_addr  <= '0;
      bus.sram_din   <= '0;
      bus.gnt0       <= 1'b0;
      bus.gnt1       <= 1'b0;
      bus.done0      <= 1'b0;
      bus.done1      <= 1'b0;
      bus.rdata0     <= '0;
      bus.rdata1     <= '0;
    end else begin
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            winner         <= pick;
            last_served    <= pick;
            bus.sram_addr  <= pick ? bus.addr1  : bus.addr0;
            bus.sram_din   <= pick ? bus.wdata1 : bus.wdata0;
            bus.sram_rw_en <= pick ? ~bus.we1   : ~bus.we0;
            bus.gnt0       <= ~pick;
            bus.gnt1       <= pick;
            phase_cnt      <= SETUP_LOAD;
            state          <= SETUP;
          end
        end

        SETUP: begin
          if (phase_cnt == '0) begin
            bus.sram_cs <= 1'b0;
            phase_cnt   <= ACCESS_LOAD;
            state       <= ACCESS;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        ACCESS: begin
          if (phase_cnt == '0) begin
            bus.sram_cs <= 1'b1;
            bus.done0   <= ~winner;
            bus.done1   <= winner;
            if (bus.sram_rw_en) begin
              if (winner) bus.rdata1 <= bus.sram_dout;
              else        bus.rdata0 <= bus.sram_dout;
            end
            state <= HOLD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        HOLD: begin
          // rw_en is released only after CS has been high for a full cycle.
          bus.sram_rw_en <= 1'b1;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
